// File: rtl/aurora_chk_pkg.sv
// Shared definitions for the Aurora 20G encoder-side pattern source and checker.
// Holds the generator state encoding, sequence-number width and default filler pattern.
// No logic; constants and types only.
package aurora_chk_pkg;

  // Width of the wrapping sequence number carried in the low bits of every beat.
  localparam int SEQ_WD = 16;

  // Width of one repetition of the filler pattern.
  localparam int FILL_WD = 48;

  // Default filler placed above the sequence number.
  localparam logic [FILL_WD-1:0] FILL_PAT_DEF = 48'hBBBB_CCCC_DDDD;

  // Generator run state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cmip_app_cnt.sv
// Saturating application event counter with synchronous clear.
// Latency: count reflects a vld strobe one cycle after it is seen.
// No backpressure; clr has priority over vld, and the count sticks at all-ones.
module cmip_app_cnt #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          vld,
  output logic [WD-1:0] cnt
);

  logic [WD-1:0] cnt_q;
  logic [WD-1:0] cnt_d;

  // Next count: clear wins, otherwise step on vld unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (vld && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(WD-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/aurora_20g_enc_gen.sv
// Test-pattern source feeding enc_vld/enc_data: {filler, seq} beats with burst length, gap and error injection.
// Latency: first beat is valid the cycle after a start; back-to-back beats at full rate when the gap is 0.
// Backpressure: a presented beat holds stable while enc_rdy is low; enc_vld only drops after a transfer.
module aurora_20g_enc_gen
  import aurora_chk_pkg::*;
#(
  parameter int                 DATA_WD  = 64,
  parameter logic [FILL_WD-1:0] FILL_PAT = FILL_PAT_DEF,
  parameter int                 GAP_WD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [31:0]        cfg_pkt_num,
  input  logic [GAP_WD-1:0]  cfg_gap,
  input  logic               cfg_err_inj,
  input  logic               enc_rdy,
  output logic               enc_vld,
  output logic [DATA_WD-1:0] enc_data,
  output logic               busy,
  output logic               done,
  output logic [31:0]        tx_cnt
);

  // Filler replicated from bit 0 upward, then shifted above the sequence field.
  localparam int REPS = (DATA_WD + FILL_WD - 1) / FILL_WD;
  localparam logic [REPS*FILL_WD-1:0] FILL_REP = {REPS{FILL_PAT}};
  localparam logic [REPS*FILL_WD+SEQ_WD-1:0] FILL_FULL = {FILL_REP, {SEQ_WD{1'b0}}};
  localparam logic [DATA_WD-1:0] FILL_BASE = FILL_FULL[DATA_WD-1:0];

  state_e              state_q, state_d;
  logic                vld_q, vld_d;
  logic [DATA_WD-1:0]  data_q, data_d;
  logic [SEQ_WD-1:0]   seq_q, seq_d;
  logic [31:0]         pkt_num_q, pkt_num_d;
  logic [GAP_WD-1:0]   gap_q, gap_d;
  logic [GAP_WD-1:0]   gap_cnt_q, gap_cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                err_pend_q, err_pend_d;
  logic                corr_q, corr_d;

  logic                xfer;
  logic                start;
  logic                last_beat;
  logic                load;
  logic                err_use;

  // Build one beat: filler above, sequence below, optionally with bit 0 inverted.
  function automatic logic [DATA_WD-1:0] mk_beat(input logic [SEQ_WD-1:0] s, input logic flip);
    logic [DATA_WD-1:0] b;
    b = FILL_BASE;
    b[SEQ_WD-1:0] = s ^ {{(SEQ_WD-1){1'b0}}, flip};
    return b;
  endfunction

  assign xfer  = vld_q && enc_rdy;
  assign start = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // tx_cnt has already counted every earlier beat, so +1 is the beat now leaving.
  assign last_beat = (pkt_num_q != 32'd0) &&
                     (({1'b0, tx_cnt} + 33'd1) == {1'b0, pkt_num_q});

  // A new beat is presented next cycle when SEND is entered or the current one leaves.
  assign load = (state_d == ST_SEND) && ((state_q != ST_SEND) || xfer);

  // The pending error is consumed by the corrupted beat leaving now, so it must not hit the next one.
  assign err_use = err_pend_q && !(xfer && corr_q);

  // Next-state selection for the run FSM.
  always_comb begin
    state_d = state_q;
    if (cfg_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) state_d = ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            if (last_beat || stop_pend_q || cfg_stop) begin
              state_d = ST_DONE;
            end else if (gap_q == '0) begin
              state_d = ST_SEND;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cfg_stop) begin
            state_d = ST_DONE;
          end else if (gap_cnt_q <= GAP_WD'(1)) begin
            state_d = ST_SEND;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and bookkeeping next values driven by the FSM transition.
  always_comb begin
    vld_d       = vld_q;
    data_d      = data_q;
    seq_d       = seq_q;
    pkt_num_d   = pkt_num_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    err_pend_d  = err_pend_q;
    corr_d      = corr_q;
    if (cfg_rst) begin
      vld_d       = 1'b0;
      data_d      = '0;
      seq_d       = '0;
      pkt_num_d   = '0;
      gap_d       = '0;
      gap_cnt_d   = '0;
      stop_pend_d = 1'b0;
      err_pend_d  = 1'b0;
      corr_d      = 1'b0;
    end else begin
      // Run configuration is frozen at start so mid-run register writes do nothing.
      if (start) begin
        pkt_num_d   = cfg_pkt_num;
        gap_d       = cfg_gap;
        stop_pend_d = 1'b0;
      end

      if ((state_q == ST_SEND) && cfg_stop) stop_pend_d = 1'b1;
      if (state_d != ST_SEND) stop_pend_d = 1'b0;

      // Sequence advances on every transfer, corrupted or not, so the checker sees one error.
      if (xfer) seq_d = seq_q + {{(SEQ_WD-1){1'b0}}, 1'b1};

      if ((state_q == ST_SEND) && xfer) begin
        gap_cnt_d = gap_q;
      end else if (state_q == ST_GAP) begin
        gap_cnt_d = gap_cnt_q - GAP_WD'(1);
      end

      if (xfer && corr_q) err_pend_d = 1'b0;
      if (cfg_err_inj) err_pend_d = 1'b1;

      vld_d = (state_d == ST_SEND);
      if (xfer) corr_d = 1'b0;
      if (load) begin
        data_d = mk_beat(seq_d, err_use);
        corr_d = err_use;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and run-configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= 1'b0;
      data_q      <= '0;
      seq_q       <= '0;
      pkt_num_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
      corr_q      <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      data_q      <= data_d;
      seq_q       <= seq_d;
      pkt_num_q   <= pkt_num_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      err_pend_q  <= err_pend_d;
      corr_q      <= corr_d;
    end
  end

  // Accepted-beat counter, restarted by every run start.
  cmip_app_cnt #(
    .WD (32)
  ) u_tx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_rst | start),
    .vld (xfer),
    .cnt (tx_cnt)
  );

  assign enc_vld  = vld_q;
  assign enc_data = data_q;
  assign busy     = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_aurora_20g_enc_gen.sv
// Directed bench for the Aurora 20G pattern source: per-cycle vector table plus hand sequences.
// Inputs change 1 ns after the rising edge; outputs are compared at that same point.
// A small checker model on the falling edge counts sequence errors on accepted beats.
module tb_aurora_20g_enc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_rst;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] cfg_pkt_num;
  logic [7:0]  cfg_gap;
  logic        cfg_err_inj;
  logic        enc_rdy;
  logic        enc_vld;
  logic [63:0] enc_data;
  logic        busy;
  logic        done;
  logic [31:0] tx_cnt;

  int errs   = 0;
  int checks = 0;

  aurora_20g_enc_gen #(
    .DATA_WD  (64),
    .FILL_PAT (48'hBBBB_CCCC_DDDD),
    .GAP_WD   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_rst     (cfg_rst),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_pkt_num (cfg_pkt_num),
    .cfg_gap     (cfg_gap),
    .cfg_err_inj (cfg_err_inj),
    .enc_rdy     (enc_rdy),
    .enc_vld     (enc_vld),
    .enc_data    (enc_data),
    .busy        (busy),
    .done        (done),
    .tx_cnt      (tx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        err;
    logic        rdy;
    logic [31:0] pkt;
    logic [7:0]  gap;
    logic        vld;
    logic [15:0] seq;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } row_t;

  row_t tbl[$];

  function automatic row_t R(input logic st, input logic sp, input logic er, input logic rd,
                             input logic [31:0] pk, input logic [7:0] gp, input logic v,
                             input logic [15:0] s, input logic b, input logic d,
                             input logic [31:0] c);
    row_t r;
    r.start = st; r.stop = sp; r.err = er; r.rdy = rd; r.pkt = pk; r.gap = gp;
    r.vld = v; r.seq = s; r.busy = b; r.done = d; r.cnt = c;
    return r;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] s);
    return {48'hBBBB_CCCC_DDDD, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply rows lo..hi-1, one clock each, and compare the post-edge outputs.
  task automatic apply(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      cfg_start   = tbl[i].start;
      cfg_stop    = tbl[i].stop;
      cfg_err_inj = tbl[i].err;
      enc_rdy     = tbl[i].rdy;
      cfg_pkt_num = tbl[i].pkt;
      cfg_gap     = tbl[i].gap;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].vld", tag, i - lo), enc_vld, tbl[i].vld);
      chk($sformatf("%s[%0d].busy", tag, i - lo), busy, tbl[i].busy);
      chk($sformatf("%s[%0d].done", tag, i - lo), done, tbl[i].done);
      chk($sformatf("%s[%0d].tx_cnt", tag, i - lo), tx_cnt, tbl[i].cnt);
      if (tbl[i].vld) chk($sformatf("%s[%0d].data", tag, i - lo), enc_data, mk(tbl[i].seq));
    end
    cfg_start = 0; cfg_stop = 0; cfg_err_inj = 0;
  endtask

  // Downstream checker model: expects contiguous sequence numbers on accepted beats.
  logic [15:0] chk_exp = 16'h0;
  int          chk_err = 0;
  always @(negedge clk) begin
    if (rst || cfg_rst) begin
      chk_exp = 16'h0;
    end else if (enc_vld && enc_rdy) begin
      if (enc_data[15:0] !== chk_exp) chk_err++;
      chk_exp = chk_exp + 16'h1;
    end
  end

  int s1, s2, s3, s4, s5, s6;
  logic [15:0] exp_seq;
  logic [63:0] prev_data;
  logic        prev_stall;
  int          ntx;

  initial begin
    // Burst of 4, no gap.
    s1 = tbl.size();
    tbl.push_back(R(1,0,0,1, 4,0, 1,16'h0000,1,0,0));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'h0001,1,0,1));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'h0002,1,0,2));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'h0003,1,0,3));
    tbl.push_back(R(0,0,0,1, 4,0, 0,16'h0000,0,1,4));
    // Gap of 3, 3 beats; mid-run config changes must be ignored.
    s2 = tbl.size();
    tbl.push_back(R(1,0,0,1, 3,3, 1,16'h0004,1,0,0));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,1));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,1));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,1));
    tbl.push_back(R(0,0,0,1, 1,9, 1,16'h0005,1,0,1));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,2));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,2));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,1,0,2));
    tbl.push_back(R(0,0,0,1, 1,9, 1,16'h0006,1,0,2));
    tbl.push_back(R(0,0,0,1, 1,9, 0,16'h0000,0,1,3));
    // Sequence wrap across FFFF.
    s3 = tbl.size();
    tbl.push_back(R(1,0,0,1, 4,0, 1,16'hFFFE,1,0,0));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'hFFFF,1,0,1));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'h0000,1,0,2));
    tbl.push_back(R(0,0,0,1, 4,0, 1,16'h0001,1,0,3));
    tbl.push_back(R(0,0,0,1, 4,0, 0,16'h0000,0,1,4));
    // Error injection: beat with seq 4 goes out as 5, next beat is a clean 5.
    s4 = tbl.size();
    tbl.push_back(R(1,0,0,1, 6,0, 1,16'h0002,1,0,0));
    tbl.push_back(R(0,0,1,1, 6,0, 1,16'h0003,1,0,1));
    tbl.push_back(R(0,0,0,1, 6,0, 1,16'h0005,1,0,2));
    tbl.push_back(R(0,0,0,1, 6,0, 1,16'h0005,1,0,3));
    tbl.push_back(R(0,0,0,1, 6,0, 1,16'h0006,1,0,4));
    tbl.push_back(R(0,0,0,1, 6,0, 1,16'h0007,1,0,5));
    tbl.push_back(R(0,0,0,1, 6,0, 0,16'h0000,0,1,6));
    // Continuous run, start while busy ignored, stop under backpressure.
    s5 = tbl.size();
    tbl.push_back(R(1,0,0,1, 0,0, 1,16'h0008,1,0,0));
    tbl.push_back(R(0,0,0,1, 0,0, 1,16'h0009,1,0,1));
    tbl.push_back(R(1,0,0,0, 0,0, 1,16'h0009,1,0,1));
    tbl.push_back(R(0,1,0,0, 0,0, 1,16'h0009,1,0,1));
    tbl.push_back(R(0,0,0,0, 0,0, 1,16'h0009,1,0,1));
    tbl.push_back(R(0,0,0,1, 0,0, 0,16'h0000,0,1,2));
    s6 = tbl.size();

    rst = 1; cfg_rst = 0; cfg_start = 0; cfg_stop = 0; cfg_err_inj = 0;
    enc_rdy = 0; cfg_pkt_num = 0; cfg_gap = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset.vld", enc_vld, 0);
    chk("reset.data", enc_data, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.tx_cnt", tx_cnt, 0);
    @(posedge clk); #1;

    apply(s1, s2, "burst4");
    apply(s2, s3, "gap3");

    // Random backpressure, 100 beats.
    cfg_pkt_num = 100; cfg_gap = 0; enc_rdy = 0; cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    exp_seq = 16'h0007; ntx = 0; prev_stall = 0; prev_data = '0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (prev_stall) begin
        chk("stall.vld", enc_vld, 1);
        chk("stall.data", enc_data, prev_data);
      end
      enc_rdy = 1'($urandom_range(0, 1));
      if (enc_vld && enc_rdy) begin
        chk("rand.data", enc_data, mk(exp_seq));
        exp_seq = exp_seq + 16'h1;
        ntx++;
      end
      prev_stall = enc_vld && !enc_rdy;
      prev_data  = enc_data;
      @(posedge clk); #1;
    end
    chk("rand.done", done, 1);
    chk("rand.beats", ntx, 100);
    chk("rand.tx_cnt", tx_cnt, 100);

    // Synchronous clear from DONE.
    cfg_rst = 1;
    @(posedge clk); #1;
    cfg_rst = 0;
    chk("cfg_rst.done", done, 0);
    chk("cfg_rst.vld", enc_vld, 0);
    chk("cfg_rst.tx_cnt", tx_cnt, 0);

    // Preload seq to FFFE by running 65534 beats.
    enc_rdy = 1; cfg_pkt_num = 32'd65534; cfg_gap = 0; cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(posedge clk); #1;
    end
    chk("preload.done", done, 1);
    chk("preload.tx_cnt", tx_cnt, 32'd65534);

    apply(s3, s4, "wrap");
    apply(s4, s5, "errinj");
    chk("checker.err_cnt", chk_err, 1);
    apply(s5, s6, "stop");

    // Asynchronous reset in the middle of a continuous run.
    enc_rdy = 1; cfg_pkt_num = 0; cfg_gap = 0; cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("arst.pre_vld", enc_vld, 1);
    rst = 1;
    #1;
    chk("arst.vld", enc_vld, 0);
    chk("arst.data", enc_data, 0);
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.tx_cnt", tx_cnt, 0);
    @(posedge clk); #1;
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
